// File: rtl/addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package addsub_pkg;

  localparam int unsigned NIB_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/addsub.sv
// 4-bit add/subtract slice: {co, s} = b + (a ^ {4{op}}) + xin.
module addsub
  import addsub_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             op_i,
  input  logic             xin_i,
  output logic [NIB_W-1:0] s_o,
  output logic             co_o
);

  logic [NIB_W-1:0] a_x;

  always_comb begin
    a_x         = (op_i == OP_SUB) ? ~a_i : a_i;
    {co_o, s_o} = (NIB_W+1)'(b_i) + (NIB_W+1)'(a_x) + (NIB_W+1)'(xin_i);
  end

endmodule

// File: rtl/addsub_seq.sv
// Wide add/subtract performed one nibble per cycle on a single shared addsub slice,
// LSB nibble first, with the carry/borrow chained through carry_q.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_res,
  output logic                   out_cout,
  output logic                   out_ovf,
  output logic                   out_zero
);

  localparam int unsigned W     = NIB_W * NIBBLES;
  localparam int unsigned CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned SH_W  = CNT_W + 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, b_q, res_q, res_d;
  logic             op_q, carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q, out_valid_q;
  logic             cout_q, ovf_q, zero_q;

  logic [SH_W-1:0]  shamt_c;
  logic [NIB_W-1:0] sl_a, sl_b, sl_s;
  logic             sl_op, sl_xin, sl_co;
  logic             last_c, ovf_d, zero_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_c)    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Slice drive: active only in RUN, zeros otherwise
  always_comb begin
    sl_a   = '0;
    sl_b   = '0;
    sl_op  = 1'b0;
    sl_xin = 1'b0;
    if (state_q == RUN) begin
      sl_a   = NIB_W'(a_q >> shamt_c);
      sl_b   = NIB_W'(b_q >> shamt_c);
      sl_op  = op_q;
      sl_xin = (cnt_q == '0) ? op_q : carry_q;
    end
  end

  addsub u_slice (
    .a_i   (sl_a),
    .b_i   (sl_b),
    .op_i  (sl_op),
    .xin_i (sl_xin),
    .s_o   (sl_s),
    .co_o  (sl_co)
  );

  // Merge the current slice sum into the result; flags see the completed word
  always_comb begin
    shamt_c = {cnt_q, 2'b00};
    last_c  = (cnt_q == LAST);
    res_d   = (res_q & ~(W'(4'hF) << shamt_c)) | (W'(sl_s) << shamt_c);
    ovf_d   = ((a_q[W-1] ^ op_q) == b_q[W-1]) && (res_d[W-1] != b_q[W-1]);
    zero_d  = (res_d == '0);
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      case (state_q)
        IDLE: if (in_valid) begin
          a_q   <= in_a;
          b_q   <= in_b;
          op_q  <= in_op;
          cnt_q <= '0;
        end
        RUN: begin
          res_q   <= res_d;
          carry_q <= sl_co;
          if (last_c) begin
            cout_q <= sl_co;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_res   = res_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Multi-cycle sequencer that performs wide add/subtract operations by driving a single shared 4-bit add/subtract slice, `addsub`, one nibble per cycle.
- Accepts a `4*NIBBLES`-bit operand pair and an op code over a valid/ready handshake.
- Chains the slice's carry/borrow through a register, LSB nibble first.
- Returns the wide result plus carry, signed-overflow and zero flags over a second valid/ready handshake.
- Sits between the control logic and the slice, so wide arithmetic reuses one slice instead of instantiating a full-width adder.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; `W = 4*NIBBLES`; legal range 1..16.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request accepted when `in_valid && in_ready`.
- `in_a` input W: operand a (the subtrahend when `in_op=1`).
- `in_b` input W: operand b.
- `in_op` input 1: 0 = add (b+a), 1 = subtract (b−a).
- `out_valid` output 1: result valid.
- `out_ready` input 1: result consumed when `out_valid && out_ready`.
- `out_res` output W: sum or difference, mod 2^W.
- `out_cout` output 1: carry out of the top nibble; for subtract, 1 = no borrow.
- `out_ovf` output 1: two's-complement signed overflow.
- `out_zero` output 1: `out_res == 0`.

## Operation
- Slice function, fixed: `{co, s} = b_nib + (a_nib ^ {4{op}}) + xin`.
- Subtract is two's complement of a. The first nibble's `xin` equals `op` (1 for subtract).
- FSM states and transitions:
  - IDLE: `in_ready=1`. On accept, latch a, b and op; clear the nibble counter; go to RUN.
  - RUN: slice inputs are nibble[`cnt`] of the latched a and b.
    - `xin = (cnt==0) ? op : carry_q`.
    - Slice sum is written into result nibble[`cnt`]; `carry_q <= co`.
    - After nibble `NIBBLES-1`: capture flags and go to DONE.
  - DONE: `out_valid=1`. Outputs hold stable until `out_ready`; on handshake go to IDLE.
- Flags, captured at the last RUN cycle:
  - `out_cout` = final slice `co`.
  - `x = a ^ {W{op}}`.
  - `out_ovf = (x[W-1]==b[W-1]) && (res[W-1]!=b[W-1])`, using the final result.
  - `out_zero = (res==0)`, including the nibble written in the last cycle.
- `in_ready` is 0 in RUN and DONE. `in_valid` in those states is ignored and not queued.
- `cnt` width is `max(1,$clog2(NIBBLES))`. The counter never wraps past `NIBBLES-1`.
- `NIBBLES=1` behaves identically with a single RUN cycle.
- Unused slice inputs in IDLE/DONE are driven to 0. The slice output is ignored outside RUN.

## Timing
- Reset, synchronous and dominant over all other inputs:
  - State → IDLE.
  - `in_ready=1` from the first cycle after reset.
  - `out_valid=0`; `out_res=0`, `out_cout=0`, `out_ovf=0`, `out_zero=0`.
  - `carry_q=0`, `cnt=0`.
- Accept at edge T. RUN occupies cycles T+1..T+NIBBLES. `out_valid` rises at T+NIBBLES+1.
- Latency is NIBBLES+1 cycles from accept to `out_valid`.
- Throughput: at most one operation per NIBBLES+2 cycles. The output handshake cycle returns to IDLE; the next accept is possible one cycle later.
- Backpressure: `out_ready=0` holds DONE and all `out_*` values indefinitely.
- Reset mid-RUN or in DONE: the operation is discarded and no result is presented.
- Simultaneous `rst` and `in_valid`: reset wins and the request is not accepted.
- `in_*` values are only sampled on the accept edge. Later changes have no effect.

## Structure
- Shared package `addsub_pkg`:
  - FSM state enum `{IDLE, RUN, DONE}`.
  - `NIB_W=4`.
  - `OP_ADD=1'b0`, `OP_SUB=1'b1`.
- One sub-module: a single instance of the existing 4-bit `addsub` slice.
- The sequencer contains only the FSM, counter, carry register, operand/result registers and flag logic. No second adder is allowed.

## Test plan
All scenarios use `NIBBLES=4`, values in hex.
- Add: a=0FFF, b=1234, op=0 → res=2233, cout=0, ovf=0, zero=0; `out_valid` exactly 5 cycles after accept.
- Subtract with borrow: a=0001, b=0000, op=1 → res=FFFF, cout=0, ovf=0, zero=0.
- Subtract to zero: a=1234, b=1234, op=1 → res=0000, cout=1, zero=1, ovf=0.
- Overflow:
  - a=7FFF, b=0001, op=0 → res=8000, ovf=1, cout=0.
  - a=0001, b=8000, op=1 → res=7FFF, ovf=1, cout=1.
- Handshake: hold `out_ready=0` for 3 cycles → `out_*` stable. Pulse `in_valid` with new operands during RUN/DONE → ignored and the first result is unchanged. Next request is accepted the cycle after the output handshake.
- Reset mid-RUN (after 2 nibbles) → next cycle IDLE, `in_ready=1`, `out_valid=0`, all outputs 0. A following add of a=0001, b=0001 yields 0002.
